aes_inv_cipher_top: RTL and testbench



---
 rtl/aes_inv_cipher_top.sv | 236 +++++++++++++++++++++++
 tb/tb_aes_inv_cipher_top.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_top.sv
// rtl/aes_inv_cipher_top.sv - iterative AES-128 inverse cipher, one round per clock.
// Macro AES_INV_KEYBUF_EN caches all 11 round keys; without it each ld re-runs the schedule.
`timescale 1ns/1ps
module aes_inv_cipher_top (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic         ld,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic [127:0] text_out,
  output logic         done,
  output logic         key_rdy,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, KEXP, DEC} state_t;
  state_t state, state_nx;

  logic [127:0] data, kreg, kfwd, rk_cur, ark, round_out;
  logic [3:0]   cnt;
  logic         fin, kld_go, ld_go;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq, acc;
    sq  = gmul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = ginv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return ginv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = inv_sbox(s[127 - 8*(r + 4*((c - r) & 3)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [3:0] i);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rcon(i), 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

`ifndef AES_INV_KEYBUF_EN
  // Undo one schedule step: rk[i-1] from rk[i].
  function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [3:0] i);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rcon(i), 24'h0};
    return {w0, w1, w2, w3};
  endfunction
`endif

  assign kfwd = key_fwd(kreg, cnt);
  assign busy = (state != IDLE);

`ifdef AES_INV_KEYBUF_EN
  logic [127:0] rk [0:10];

  assign kld_go = kld && (state != DEC);
  assign ld_go  = ld && !kld && key_rdy && (state == IDLE);
  assign rk_cur = rk[cnt];

  always_ff @(posedge clk) begin
    if (kld_go)             rk[0]   <= key;
    else if (state == KEXP) rk[cnt] <= kfwd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        key_rdy <= 1'b0;
    else if (kld_go)                                 key_rdy <= 1'b0;
    else if (state == KEXP && cnt == 4'd10)          key_rdy <= 1'b1;
  end
`else
  logic unused_kld;
  assign unused_kld = kld;
  assign kld_go     = 1'b0;
  assign ld_go      = ld && (state == IDLE);
  assign rk_cur     = kreg;
  assign key_rdy    = 1'b1;
`endif

  always_comb begin
    ark = inv_shift_sub(data) ^ rk_cur;
    case (cnt)
      4'd10:   round_out = data ^ rk_cur;
      4'd0:    round_out = ark;
      default: round_out = inv_mix(ark);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (kld_go)     state_nx = KEXP;
`ifdef AES_INV_KEYBUF_EN
        else if (ld_go) state_nx = DEC;
`else
        else if (ld_go) state_nx = KEXP;
`endif
      end
      KEXP: begin
`ifdef AES_INV_KEYBUF_EN
        if (!kld_go && cnt == 4'd10) state_nx = IDLE;
`else
        if (cnt == 4'd10) state_nx = DEC;
`endif
      end
      DEC:     if (fin) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data     <= '0;
      kreg     <= '0;
      cnt      <= '0;
      fin      <= 1'b0;
      text_out <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kld_go) begin
        kreg <= key;
        cnt  <= 4'd1;
      end else if (ld_go) begin
        data <= text_in;
`ifdef AES_INV_KEYBUF_EN
        cnt  <= 4'd10;
`else
        kreg <= key;
        cnt  <= 4'd1;
`endif
      end else if (state == KEXP) begin
        // cnt is left at 10 after the last step, which is where DEC starts counting down.
        kreg <= kfwd;
        if (cnt != 4'd10) cnt <= cnt + 4'd1;
      end else if (state == DEC) begin
        if (fin) begin
          text_out <= data;
          done     <= 1'b1;
          fin      <= 1'b0;
        end else begin
          data <= round_out;
`ifndef AES_INV_KEYBUF_EN
          kreg <= key_bwd(kreg, cnt);
`endif
          if (cnt == 4'd0) fin <= 1'b1;
          else             cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// tb/tb_aes_inv_cipher_top.sv - self-checking bench for aes_inv_cipher_top against a byte-level AES model.
`timescale 1ns/1ps
module tb_aes_inv_cipher_top;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] LB_KEY = 128'hcafebabedeadbeefdeadbeef00000000;
  localparam logic [127:0] LB_PT  = 128'h0C3B9493095D2539E1E3FC5D8CC8B7E2;

`ifdef AES_INV_KEYBUF_EN
  localparam int   LAT = 12;
  localparam int   KLAT = 10;
  localparam logic KRDY_RESET = 1'b0;
  localparam int   KLD_LD_DONES = 0;
`else
  localparam int   LAT = 22;
  localparam int   KLAT = 0;
  localparam logic KRDY_RESET = 1'b1;
  localparam int   KLD_LD_DONES = 1;
`endif

  logic         clk, rst, kld, ld;
  logic [127:0] key, text_in, text_out;
  logic         done, key_rdy, busy;

  int checks = 0;
  int failures = 0;
  int n_done = 0;
  logic chk_en = 1'b0;

  aes_inv_cipher_top dut (
    .clk(clk), .rst(rst), .kld(kld), .ld(ld), .key(key), .text_in(text_in),
    .text_out(text_out), .done(done), .key_rdy(key_rdy), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h11b << (i - 8));
    return prod[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[a]  = s;
      isb[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] model_rk(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [127:0] k);
    logic [7:0]   m [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    logic [127:0] v;
    cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    v = ct ^ model_rk(k, 10);
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m[r][c] = v[127 - 8*(4*c + r) -: 8];
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) t[r][(c + r) % 4] = isb[m[r][c]];
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) v[127 - 8*(4*c + r) -: 8] = t[r][c];
      v = v ^ model_rk(k, rnd);
      if (rnd > 0) begin
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m[r][c] = v[127 - 8*(4*c + r) -: 8];
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
          acc = 8'h00;
          for (int j = 0; j < 4; j++) acc = acc ^ gm(cf[(j - r + 4) % 4], m[j][c]);
          v[127 - 8*(4*c + r) -: 8] = acc;
        end
      end
    end
    return v;
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]   m [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    logic [127:0] v;
    cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    v = pt ^ model_rk(k, 0);
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m[r][c] = v[127 - 8*(4*c + r) -: 8];
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) t[r][c] = sb[m[r][(c + r) % 4]];
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          acc = 8'h00;
          for (int j = 0; j < 4; j++) acc = acc ^ gm(cf[(j - r + 4) % 4], t[j][c]);
        end else acc = t[r][c];
        v[127 - 8*(4*c + r) -: 8] = acc;
      end
      v = v ^ model_rk(k, rnd);
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Cycle-level protocol model: countdowns of remaining busy cycles per operation.
  int           m_kleft, m_dleft;
  logic         m_done, m_key_rdy;
  logic [127:0] m_out, m_pend, m_key;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_kleft   <= 0;
      m_dleft   <= 0;
      m_done    <= 1'b0;
      m_out     <= '0;
      m_key_rdy <= KRDY_RESET;
    end else begin
      m_done <= 1'b0;
      if (m_dleft != 0) begin
        m_dleft <= m_dleft - 1;
        if (m_dleft == 1) begin
          m_done <= 1'b1;
          m_out  <= m_pend;
        end
      end
`ifdef AES_INV_KEYBUF_EN
      if (kld && m_dleft == 0) begin
        m_kleft   <= 10;
        m_key_rdy <= 1'b0;
        m_key     <= key;
      end else begin
        if (m_kleft != 0) begin
          m_kleft <= m_kleft - 1;
          if (m_kleft == 1) m_key_rdy <= 1'b1;
        end
        if (ld && m_kleft == 0 && m_dleft == 0 && m_key_rdy) begin
          m_dleft <= 12;
          m_pend  <= model_dec(text_in, m_key);
        end
      end
`else
      if (ld && m_dleft == 0) begin
        m_dleft <= 22;
        m_pend  <= model_dec(text_in, key);
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (rst && chk_en) begin
      check("done", 128'(done), 128'(m_done));
      check("busy", 128'(busy), 128'((m_kleft != 0) || (m_dleft != 0)));
      check("key_rdy", 128'(key_rdy), 128'(m_key_rdy));
      check("text_out", text_out, m_out);
      if (done) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_kld(input logic [127:0] k);
    kld = 1'b1;
    key = k;
    tick();
    kld = 1'b0;
  endtask

  task automatic do_ld(input logic [127:0] ct, input logic [127:0] k);
    ld      = 1'b1;
    text_in = ct;
    key     = k;
    tick();
    ld = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_krdy(output int n);
    n = 0;
    while (key_rdy !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, d0;
    logic [127:0] lb_ct, cur_key;
    rst = 1'b0; kld = 1'b0; ld = 1'b0; key = '0; text_in = '0;
    build_tables();

    check("model_dec_c1", model_dec(C1_CT, C1_KEY), C1_PT);
    check("model_dec_b", model_dec(B_CT, B_KEY), B_PT);
    check("model_enc_b", model_enc(B_PT, B_KEY), B_CT);

    repeat (2) @(posedge clk);
    #1;
    check("rst_text_out", text_out, 128'h0);
    check("rst_done", 128'(done), 128'h0);
    check("rst_busy", 128'(busy), 128'h0);
    check("rst_key_rdy", 128'(key_rdy), 128'(KRDY_RESET));
    rst = 1'b1;
    chk_en = 1'b1;

    do_ld(C1_CT, C1_KEY);
    idle(26);

    do_kld(C1_KEY);
    wait_krdy(n);
    check("c1_key_latency", 128'(n), 128'(KLAT));
    do_ld(C1_CT, C1_KEY);
    wait_done(n);
    check("c1_latency", 128'(n), 128'(LAT));
    check("c1_plaintext", text_out, C1_PT);

    do_kld(B_KEY);
    wait_krdy(n);
    do_ld(B_CT, B_KEY);
    wait_done(n);
    check("b_plaintext", text_out, B_PT);
    do_ld(C1_CT, B_KEY);
    wait_done(n);
    check("b2b_latency", 128'(n), 128'(LAT));
    check("b2b_plaintext", text_out, model_dec(C1_CT, B_KEY));

    do_ld(B_CT, B_KEY);
    idle(3);
    do_ld(C1_CT, B_KEY);
    wait_done(n);
    check("ld_in_dec_result", text_out, B_PT);
    idle(30);

    d0 = n_done;
    kld = 1'b1; ld = 1'b1; key = C1_KEY; text_in = C1_CT;
    tick();
    kld = 1'b0; ld = 1'b0;
    idle(30);
    check("kld_ld_dones", 128'(n_done - d0), 128'(KLD_LD_DONES));

    lb_ct = model_enc(LB_PT, LB_KEY);
    do_kld(LB_KEY);
    wait_krdy(n);
    do_ld(lb_ct, LB_KEY);
    wait_done(n);
    check("loopback", text_out, LB_PT);

    do_ld(lb_ct, LB_KEY);
    idle(4);
    #2 rst = 1'b0;
    #1;
    check("arst_text_out", text_out, 128'h0);
    check("arst_done", 128'(done), 128'h0);
    check("arst_busy", 128'(busy), 128'h0);
    check("arst_key_rdy", 128'(key_rdy), 128'(KRDY_RESET));
    tick();
    rst = 1'b1;
    do_kld(C1_KEY);
    wait_krdy(n);
    do_ld(C1_CT, C1_KEY);
    wait_done(n);
    check("post_rst_plaintext", text_out, C1_PT);

    do_kld(B_KEY);
    idle(3);
    do_kld(C1_KEY);
    wait_krdy(n);
    check("kchg_key_latency", 128'(n), 128'(KLAT));
    do_ld(C1_CT, C1_KEY);
    wait_done(n);
    check("kchg_plaintext", text_out, C1_PT);

    cur_key = C1_KEY;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        cur_key = {$urandom, $urandom, $urandom, $urandom};
        do_kld(cur_key);
        idle($urandom_range(0, 12));
      end
      do_ld({$urandom, $urandom, $urandom, $urandom}, cur_key);
      idle($urandom_range(0, 25));
    end
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
